mss_core3_sys: RTL and testbench

- Synthesizable stand-in for the SmartFusion microcontroller subsystem wrapper: UART-driven AHB-Lite master (debug bridge), fabric reset/clock generation, GPI sampling and an idle RMII MAC interface.
- Sits between the board pins (UART, RMII, reset) and the FPGA fabric AHB bus (MSSH*).

---
 rtl/mss_core3_pkg.sv | 38 +++
 rtl/mss_uart.sv | 170 +++++++++++++++++
 rtl/mss_core3_sys.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mss_core3_sys.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mss_core3_pkg.sv
// Shared constants and state encodings for the MSS debug-bridge stand-in.
package mss_core3_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] CMD_GPI     = 8'h47;
  localparam logic [7:0] RSP_OKAY    = 8'h4B;
  localparam logic [7:0] RSP_ERROR   = 8'h45;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_AHB_ADDR,
    ST_AHB_DATA,
    ST_REPLY
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/mss_uart.sv
// 8N1 UART receiver and transmitter; RX flags a zero stop bit as a framing error.
module mss_uart
  import mss_core3_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o,
  output logic       txd_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;
  logic             tx_busy_q, tx_busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rxd_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Receiver: falling edge opens a frame, start confirmed half a bit later.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == CNT_W'(HALF - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter: line driven from a register so every bit is exactly one bit time.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_valid_i) begin
          tx_sh_d    = tx_data_i;
          txd_d      = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_sh_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign rx_data_o  = rx_sh_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_ferr_o  = rx_ferr_q;
  assign tx_busy_o  = tx_busy_q;
  assign txd_o      = txd_q;

endmodule

// File: rtl/mss_core3_sys.sv
// MSS wrapper stand-in: UART command parser driving a single-word AHB-Lite master,
// fabric reset stretcher, MDC divider and an idle RMII transmit interface.
module mss_core3_sys
  import mss_core3_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 87,
  parameter int unsigned RST_STRETCH    = 16,
  parameter int unsigned HREADY_TIMEOUT = 1024,
  parameter int unsigned MDC_DIV        = 4
) (
  input  logic        MAC_CLK,
  input  logic        MSS_RESET_N,
  input  logic        MAINXIN,
  input  logic        MSSHREADY,
  input  logic        MSSHRESP,
  input  logic [31:0] MSSHRDATA,
  output logic [31:0] MSSHADDR,
  output logic [1:0]  MSSHTRANS,
  output logic [2:0]  MSSHSIZE,
  output logic        MSSHWRITE,
  output logic        MSSHLOCK,
  output logic [31:0] MSSHWDATA,
  input  logic        F2M_GPI_3,
  input  logic        F2M_GPI_2,
  input  logic        F2M_GPI_1,
  input  logic        F2M_GPI_0,
  input  logic        UART_0_RXD,
  output logic        UART_0_TXD,
  output logic        M2F_RESET_N,
  output logic        FAB_CLK,
  input  logic [1:0]  MAC_RXD,
  input  logic        MAC_CRSDV,
  input  logic        MAC_RXER,
  output logic [1:0]  MAC_TXD,
  output logic        MAC_TXEN,
  output logic        MAC_MDC,
  inout  wire         MAC_MDIO
);

  localparam int unsigned RST_CW = $clog2(RST_STRETCH + 1);
  localparam int unsigned TMO_CW = $clog2(HREADY_TIMEOUT + 1);
  localparam int unsigned MDC_CW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

  logic [1:0]        rst_sync_q;
  logic [RST_CW-1:0] rst_cnt_q;
  logic              m2f_rst_n_q;
  logic [MDC_CW-1:0] mdc_cnt_q;
  logic              mdc_q;
  logic [3:0]        gpi_s1_q, gpi_s2_q;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [39:0]       reply_q, reply_d;
  logic [2:0]        reply_len_q, reply_len_d;
  logic [TMO_CW-1:0] tmo_q, tmo_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [31:0]       haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              tx_busy;
  logic              unused_pins_c;

  mss_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i     (MAC_CLK),
    .rst_ni    (MSS_RESET_N),
    .rxd_i     (UART_0_RXD),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_ferr_o (rx_ferr),
    .tx_valid_i(tx_valid_q),
    .tx_data_i (tx_data_q),
    .tx_busy_o (tx_busy),
    .txd_o     (UART_0_TXD)
  );

  // Fabric reset: asserts with MSS_RESET_N, releases RST_STRETCH cycles after the synchronized release.
  always_ff @(posedge MAC_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      rst_sync_q  <= '0;
      rst_cnt_q   <= '0;
      m2f_rst_n_q <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      if (rst_sync_q[1] && !m2f_rst_n_q) begin
        if (rst_cnt_q == RST_CW'(RST_STRETCH - 1)) m2f_rst_n_q <= 1'b1;
        else rst_cnt_q <= rst_cnt_q + RST_CW'(1);
      end
    end
  end

  always_ff @(posedge MAC_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      mdc_cnt_q <= '0;
      mdc_q     <= 1'b0;
      gpi_s1_q  <= '0;
      gpi_s2_q  <= '0;
    end else begin
      gpi_s1_q <= {F2M_GPI_3, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0};
      gpi_s2_q <= gpi_s1_q;
      if (mdc_cnt_q == MDC_CW'(MDC_DIV - 1)) begin
        mdc_cnt_q <= '0;
        mdc_q     <= ~mdc_q;
      end else begin
        mdc_cnt_q <= mdc_cnt_q + MDC_CW'(1);
      end
    end
  end

  always_ff @(posedge MAC_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      reply_q     <= '0;
      reply_len_q <= '0;
      tmo_q       <= '0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reply_q     <= reply_d;
      reply_len_q <= reply_len_d;
      tmo_q       <= tmo_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Command parser and AHB master; NONSEQ is driven for exactly the AHB_ADDR cycle.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    reply_d     = reply_q;
    reply_len_d = reply_len_q;
    tmo_d       = tmo_q;
    htrans_d    = HTRANS_IDLE;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    tx_valid_d  = 1'b0;
    tx_data_d   = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else if (rx_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else if (rx_data == CMD_GPI) begin
            reply_d     = {4'b0000, gpi_s2_q, 32'h0};
            reply_len_d = 3'd1;
            state_d     = ST_REPLY;
          end
        end
      end
      ST_ADDR: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              htrans_d = HTRANS_NONSEQ;
              haddr_d  = {addr_q[23:0], rx_data};
              hwrite_d = 1'b0;
              state_d  = ST_AHB_ADDR;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_ferr) begin
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          wdata_d    = {wdata_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = addr_q;
            hwrite_d = 1'b1;
            state_d  = ST_AHB_ADDR;
          end
        end
      end
      ST_AHB_ADDR: begin
        tmo_d = '0;
        if (hwrite_q) hwdata_d = wdata_q;
        state_d = ST_AHB_DATA;
      end
      ST_AHB_DATA: begin
        if (MSSHREADY || tmo_q == TMO_CW'(HREADY_TIMEOUT - 1)) begin
          haddr_d     = '0;
          hwrite_d    = 1'b0;
          hwdata_d    = '0;
          reply_len_d = 3'd1;
          state_d     = ST_REPLY;
          if (!MSSHREADY) begin
            reply_d = {RSP_TIMEOUT, 32'h0};
          end else if (MSSHRESP) begin
            reply_d = {RSP_ERROR, 32'h0};
          end else if (hwrite_q) begin
            reply_d = {RSP_OKAY, 32'h0};
          end else begin
            reply_d     = {RSP_OKAY, MSSHRDATA};
            reply_len_d = 3'd5;
          end
        end else begin
          tmo_d = tmo_q + TMO_CW'(1);
        end
      end
      ST_REPLY: begin
        if (!tx_busy && !tx_valid_q) begin
          if (reply_len_q != 3'd0) begin
            tx_valid_d  = 1'b1;
            tx_data_d   = reply_q[39:32];
            reply_d     = {reply_q[31:0], 8'h00};
            reply_len_d = reply_len_q - 3'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MSSHTRANS   = htrans_q;
  assign MSSHADDR    = haddr_q;
  assign MSSHWRITE   = hwrite_q;
  assign MSSHWDATA   = hwdata_q;
  assign MSSHSIZE    = HSIZE_WORD;
  assign MSSHLOCK    = 1'b0;
  assign M2F_RESET_N = m2f_rst_n_q;
  assign FAB_CLK     = MAC_CLK;
  assign MAC_MDC     = mdc_q;
  assign MAC_TXD     = 2'b00;
  assign MAC_TXEN    = 1'b0;
  assign MAC_MDIO    = 1'bz;

  assign unused_pins_c = ^{MAINXIN, MAC_RXD, MAC_CRSDV, MAC_RXER};

endmodule

// File: tb/tb_mss_core3_sys.sv
// Scoreboard bench for mss_core3_sys: UART command stimulus, AHB slave model, reply monitor.
module tb_mss_core3_sys;

  localparam int CPB = 87;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        resp;
    logic        hang;
  } ahb_t;

  logic        MAC_CLK, MSS_RESET_N, MAINXIN;
  logic        MSSHREADY, MSSHRESP;
  logic [31:0] MSSHRDATA;
  logic        F2M_GPI_3, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0;
  logic        UART_0_RXD;
  logic [1:0]  MAC_RXD;
  logic        MAC_CRSDV, MAC_RXER;
  wire  [31:0] MSSHADDR, MSSHWDATA;
  wire  [1:0]  MSSHTRANS, MAC_TXD;
  wire  [2:0]  MSSHSIZE;
  wire         MSSHWRITE, MSSHLOCK, UART_0_TXD, M2F_RESET_N, FAB_CLK;
  wire         MAC_TXEN, MAC_MDC;
  wire         mdio_unused;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] rsp_q[$];
  ahb_t       ahb_q[$];

  mss_core3_sys dut (
    .MAC_CLK(MAC_CLK), .MSS_RESET_N(MSS_RESET_N), .MAINXIN(MAINXIN),
    .MSSHREADY(MSSHREADY), .MSSHRESP(MSSHRESP), .MSSHRDATA(MSSHRDATA),
    .MSSHADDR(MSSHADDR), .MSSHTRANS(MSSHTRANS), .MSSHSIZE(MSSHSIZE),
    .MSSHWRITE(MSSHWRITE), .MSSHLOCK(MSSHLOCK), .MSSHWDATA(MSSHWDATA),
    .F2M_GPI_3(F2M_GPI_3), .F2M_GPI_2(F2M_GPI_2), .F2M_GPI_1(F2M_GPI_1), .F2M_GPI_0(F2M_GPI_0),
    .UART_0_RXD(UART_0_RXD), .UART_0_TXD(UART_0_TXD),
    .M2F_RESET_N(M2F_RESET_N), .FAB_CLK(FAB_CLK),
    .MAC_RXD(MAC_RXD), .MAC_CRSDV(MAC_CRSDV), .MAC_RXER(MAC_RXER),
    .MAC_TXD(MAC_TXD), .MAC_TXEN(MAC_TXEN), .MAC_MDC(MAC_MDC), .MAC_MDIO(mdio_unused)
  );

  initial begin
    MAC_CLK = 1'b0;
    forever #5 MAC_CLK = ~MAC_CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    UART_0_RXD = 1'b0;
    repeat (CPB) @(negedge MAC_CLK);
    for (int i = 0; i < 8; i++) begin
      UART_0_RXD = b[i];
      repeat (CPB) @(negedge MAC_CLK);
    end
    UART_0_RXD = stop_bit;
    repeat (CPB) @(negedge MAC_CLK);
    UART_0_RXD = 1'b1;
    if (!stop_bit) repeat (2 * CPB) @(negedge MAC_CLK);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (rsp_q.size() != 0 && n < 20000) begin
      @(posedge MAC_CLK);
      n++;
    end
    if (rsp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_reply_timeout pending=%0d required=0", name, rsp_q.size());
      rsp_q.delete();
    end
    repeat (2 * CPB) @(negedge MAC_CLK);
    check({name, "_ahb_pending"}, 32'(ahb_q.size()), 32'd0);
  endtask

  // AHB slave model and address/data-phase checker.
  initial begin : ahb_slave
    ahb_t t;
    MSSHREADY = 1'b0;
    MSSHRESP  = 1'b0;
    MSSHRDATA = '0;
    forever begin
      @(posedge MAC_CLK);
      #1;
      if (MSSHTRANS == 2'b10) begin
        if (ahb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_nonseq actual=%0h required=none", MSSHADDR);
        end else begin
          t = ahb_q.pop_front();
          check("haddr", MSSHADDR, t.addr);
          check("hwrite", 32'(MSSHWRITE), 32'(t.wr));
          check("hsize", 32'(MSSHSIZE), 32'd2);
          check("hlock", 32'(MSSHLOCK), 32'd0);
          @(posedge MAC_CLK);
          #1;
          check("htrans_single_nonseq", 32'(MSSHTRANS), 32'd0);
          if (!t.hang) begin
            for (int w = 0; w < t.waits; w++) begin
              if (t.wr) check("hwdata_wait", MSSHWDATA, t.wdata);
              @(posedge MAC_CLK);
              #1;
            end
            if (t.wr) check("hwdata_ready", MSSHWDATA, t.wdata);
            MSSHREADY = 1'b1;
            MSSHRESP  = t.resp;
            MSSHRDATA = t.rdata;
            @(posedge MAC_CLK);
            #1;
            MSSHREADY = 1'b0;
            MSSHRESP  = 1'b0;
            MSSHRDATA = '0;
          end
        end
      end
    end
  end

  // Reply monitor: decode each TX frame and compare against the scoreboard.
  initial begin : reply_mon
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge UART_0_TXD);
      repeat (CPB / 2) @(negedge MAC_CLK);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge MAC_CLK);
        b[i] = UART_0_TXD;
      end
      repeat (CPB) @(negedge MAC_CLK);
      stop_bit = UART_0_TXD;
      check("tx_stop_bit", 32'(stop_bit), 32'd1);
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_reply actual=%0h required=none", b);
      end else begin
        check("reply_byte", 32'(b), 32'(rsp_q.pop_front()));
      end
    end
  end

  initial begin : stimulus
    int   n;
    int   toggles;
    logic seen;
    logic prev;
    MAINXIN    = 1'b0;
    UART_0_RXD = 1'b1;
    MAC_RXD    = 2'b00;
    MAC_CRSDV  = 1'b0;
    MAC_RXER   = 1'b0;
    {F2M_GPI_3, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0} = 4'b0000;
    MSS_RESET_N = 1'b1;
    #2;
    MSS_RESET_N = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge MAC_CLK);
      check("rst_txd", 32'(UART_0_TXD), 32'd1);
      check("rst_htrans", 32'(MSSHTRANS), 32'd0);
      check("rst_m2f", 32'(M2F_RESET_N), 32'd0);
      check("rst_mdc", 32'(MAC_MDC), 32'd0);
    end
    check("rst_haddr", MSSHADDR, 32'd0);
    check("rst_hwdata", MSSHWDATA, 32'd0);
    check("rst_hwrite", 32'(MSSHWRITE), 32'd0);
    check("rst_hsize", 32'(MSSHSIZE), 32'd2);
    check("rst_txen", 32'(MAC_TXEN), 32'd0);
    check("rst_txd_rmii", 32'(MAC_TXD), 32'd0);
    MSS_RESET_N = 1'b1;

    // 2 synchronizer edges plus 16 stretch cycles.
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge MAC_CLK);
      #1;
      n++;
      if (M2F_RESET_N) seen = 1'b1;
      else begin
        check("stretch_txd", 32'(UART_0_TXD), 32'd1);
        check("stretch_htrans", 32'(MSSHTRANS), 32'd0);
        check("stretch_txen", 32'(MAC_TXEN), 32'd0);
      end
    end
    check("m2f_release_cycles", 32'(n), 32'd18);

    toggles = 0;
    prev = MAC_MDC;
    for (int i = 0; i < 40; i++) begin
      @(negedge MAC_CLK);
      if (MAC_MDC != prev) toggles++;
      prev = MAC_MDC;
    end
    check("mdc_toggles_40", 32'(toggles), 32'd10);
    #1;
    check("fab_clk_low", 32'(FAB_CLK), 32'd0);
    @(posedge MAC_CLK);
    #1;
    check("fab_clk_high", 32'(FAB_CLK), 32'd1);
    @(negedge MAC_CLK);

    // Write with two wait states.
    ahb_q.push_back('{addr: 32'h0000_1000, wr: 1'b1, wdata: 32'hDEAD_BEEF, waits: 2,
                      rdata: 32'h0, resp: 1'b0, hang: 1'b0});
    rsp_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    wait_done("write");

    // Read OKAY.
    ahb_q.push_back('{addr: 32'h0000_2000, wr: 1'b0, wdata: 32'h0, waits: 0,
                      rdata: 32'h1234_5678, resp: 1'b0, hang: 1'b0});
    rsp_q.push_back(8'h4B); rsp_q.push_back(8'h12); rsp_q.push_back(8'h34);
    rsp_q.push_back(8'h56); rsp_q.push_back(8'h78);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
    wait_done("read_ok");

    // Read ERROR response.
    ahb_q.push_back('{addr: 32'h0000_3004, wr: 1'b0, wdata: 32'h0, waits: 0,
                      rdata: 32'hFFFF_FFFF, resp: 1'b1, hang: 1'b0});
    rsp_q.push_back(8'h45);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h04, 1'b1);
    wait_done("read_err");

    // Read with HREADY never asserted.
    ahb_q.push_back('{addr: 32'hA5A5_0001, wr: 1'b0, wdata: 32'h0, waits: 0,
                      rdata: 32'h0, resp: 1'b0, hang: 1'b1});
    rsp_q.push_back(8'h54);
    send_byte(8'h52, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    wait_done("read_timeout");
    check("timeout_bus_idle", 32'(MSSHTRANS), 32'd0);
    check("timeout_hwrite", 32'(MSSHWRITE), 32'd0);

    {F2M_GPI_3, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0} = 4'b1010;
    rsp_q.push_back(8'h0A);
    send_byte(8'h47, 1'b1);
    wait_done("gpi_a");

    // Framing error mid-address, then a GPI read.
    {F2M_GPI_3, F2M_GPI_2, F2M_GPI_1, F2M_GPI_0} = 4'b0101;
    rsp_q.push_back(8'h05);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    send_byte(8'h47, 1'b1);
    wait_done("ferr_gpi");

    check("end_txen", 32'(MAC_TXEN), 32'd0);
    check("end_txd_idle", 32'(UART_0_TXD), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
